// File: rtl/alu16_pkg.sv
// Shared constants for the EX/MEM slice of the 16-bit CPU:
// ALUOp codes, opcodes, ALUCtrl encodings and default data-memory depth.
package alu16_pkg;

   localparam logic [1:0] ALUOP_MEM   = 2'b00;
   localparam logic [1:0] ALUOP_BEQ   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE = 2'b11;

   localparam logic [3:0] OPC_R0   = 4'b0000;
   localparam logic [3:0] OPC_R1   = 4'b0001;
   localparam logic [3:0] OPC_ADDI = 4'b0010;
   localparam logic [3:0] OPC_SUBI = 4'b0011;
   localparam logic [3:0] OPC_SLTI = 4'b0100;
   localparam logic [3:0] OPC_ANDI = 4'b0101;
   localparam logic [3:0] OPC_ORI  = 4'b0110;
   localparam logic [3:0] OPC_XORI = 4'b0111;

   localparam logic [3:0] CTRL_AND = 4'b0000;
   localparam logic [3:0] CTRL_OR  = 4'b0001;
   localparam logic [3:0] CTRL_ADD = 4'b0010;
   localparam logic [3:0] CTRL_SUB = 4'b1010;
   localparam logic [3:0] CTRL_SLT = 4'b1011;
   localparam logic [3:0] CTRL_XOR = 4'b0100;
   localparam logic [3:0] CTRL_NOR = 4'b0101;
   localparam logic [3:0] CTRL_SLL = 4'b0110;
   localparam logic [3:0] CTRL_SRL = 4'b0111;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SLT = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOR = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;
   localparam logic [2:0] OP_SRL = 3'b111;

   localparam int DMEM_DEPTH = 256;

endpackage

// File: rtl/alu16_ctrl.sv
// ALU-control decoder: ALUOp/Funct/Opcode -> 4-bit ALUCtrl.
// Every undefined combination falls back to ADD.
module alu16_ctrl
   import alu16_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [1:0] funct,
   input  logic [3:0] opcode,
   output logic [3:0] alu_ctrl
);

   logic [3:0] r_ctrl;
   logic [3:0] i_ctrl;

   always_comb begin
      r_ctrl = CTRL_ADD;
      if (opcode == OPC_R0) begin
         unique case (funct)
            2'b00: r_ctrl = CTRL_ADD;
            2'b01: r_ctrl = CTRL_SUB;
            2'b10: r_ctrl = CTRL_SLT;
            2'b11: r_ctrl = CTRL_AND;
         endcase
      end else if (opcode == OPC_R1) begin
         unique case (funct)
            2'b00: r_ctrl = CTRL_OR;
            2'b01: r_ctrl = CTRL_XOR;
            2'b10: r_ctrl = CTRL_SLL;
            2'b11: r_ctrl = CTRL_SRL;
         endcase
      end
   end

   always_comb begin
      i_ctrl = CTRL_ADD;
      case (opcode)
         OPC_ADDI: i_ctrl = CTRL_ADD;
         OPC_SUBI: i_ctrl = CTRL_SUB;
         OPC_SLTI: i_ctrl = CTRL_SLT;
         OPC_ANDI: i_ctrl = CTRL_AND;
         OPC_ORI:  i_ctrl = CTRL_OR;
         OPC_XORI: i_ctrl = CTRL_XOR;
         default:  i_ctrl = CTRL_ADD;
      endcase
   end

   always_comb begin
      alu_ctrl = CTRL_ADD;
      unique case (alu_op)
         ALUOP_MEM:   alu_ctrl = CTRL_ADD;
         ALUOP_BEQ:   alu_ctrl = CTRL_SUB;
         ALUOP_RTYPE: alu_ctrl = r_ctrl;
         ALUOP_ITYPE: alu_ctrl = i_ctrl;
      endcase
   end

endmodule

// File: rtl/alu16_exec.sv
// EX/MEM slice: ALU-control decoder, 16-bit ALU and big-endian byte data memory.
// ALU16_EXEC_SHIFT_EN enables SLL/SRL; without it shift ops yield zero.
module alu16_exec
   import alu16_pkg::*;
#(
   parameter int DMEM_BYTES = DMEM_DEPTH
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [1:0]  ALUOp,
   input  logic [1:0]  Funct,
   input  logic [3:0]  Opcode,
   input  logic [15:0] OperandA,
   input  logic [15:0] OperandB,
   input  logic [15:0] StoreData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [3:0]  ALUCtrl,
   output logic [15:0] ALUOut,
   output logic        Zero,
   output logic        Overflow,
   output logic        CarryOut,
   output logic [15:0] MemData
);

   localparam int AW = $clog2(DMEM_BYTES);

   logic        binv;
   logic [2:0]  op;
   logic [15:0] b_eff;
   logic [16:0] sum;
   logic        slt;
   logic [AW-1:0] addr_hi;
   logic [AW-1:0] addr_lo;
   logic [7:0]  mem [DMEM_BYTES];

   alu16_ctrl u_ctrl (
      .alu_op   (ALUOp),
      .funct    (Funct),
      .opcode   (Opcode),
      .alu_ctrl (ALUCtrl)
   );

   assign binv = ALUCtrl[3];
   assign op   = ALUCtrl[2:0];

   // Shared adder: SUB is A + ~B + 1, so CarryOut=1 means no borrow
   always_comb begin
      b_eff = binv ? ~OperandB : OperandB;
      sum   = {1'b0, OperandA} + {1'b0, b_eff} + {16'd0, binv};
      slt   = $signed(OperandA) < $signed(OperandB);
   end

   always_comb begin
      ALUOut   = '0;
      Overflow = 1'b0;
      CarryOut = 1'b0;
      unique case (op)
         OP_AND: ALUOut = OperandA & OperandB;
         OP_OR:  ALUOut = OperandA | OperandB;
         OP_ADD: begin
            ALUOut   = sum[15:0];
            CarryOut = sum[16];
            Overflow = (OperandA[15] == b_eff[15]) &&
                       (sum[15] != OperandA[15]);
         end
         OP_SLT: ALUOut = {15'd0, slt};
         OP_XOR: ALUOut = OperandA ^ OperandB;
         OP_NOR: ALUOut = ~(OperandA | OperandB);
`ifdef ALU16_EXEC_SHIFT_EN
         OP_SLL: ALUOut = OperandA << OperandB[3:0];
         OP_SRL: ALUOut = OperandA >> OperandB[3:0];
`else
         OP_SLL: ALUOut = '0;
         OP_SRL: ALUOut = '0;
`endif
      endcase
   end

   assign Zero = (ALUOut == 16'd0);

   // Bit 0 of the address is ignored; upper bits wrap modulo depth
   assign addr_hi = {ALUOut[AW-1:1], 1'b0};
   assign addr_lo = {ALUOut[AW-1:1], 1'b1};

   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int i = 0; i < DMEM_BYTES; i++) begin
            mem[i] <= 8'd0;
         end
      end else if (MemWrite) begin
         mem[addr_hi] <= StoreData[15:8];
         mem[addr_lo] <= StoreData[7:0];
      end
   end

   assign MemData = MemRead ? {mem[addr_hi], mem[addr_lo]} : 16'd0;

endmodule

// File: tb/tb_alu16_exec.sv
// Directed-vector bench for alu16_exec.
// Expected values are hand-computed constants.
module tb_alu16_exec;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [1:0]  ALUOp;
   logic [1:0]  Funct;
   logic [3:0]  Opcode;
   logic [15:0] OperandA;
   logic [15:0] OperandB;
   logic [15:0] StoreData;
   logic        MemWrite;
   logic        MemRead;
   logic [3:0]  ALUCtrl;
   logic [15:0] ALUOut;
   logic        Zero;
   logic        Overflow;
   logic        CarryOut;
   logic [15:0] MemData;

   int total = 0;
   int bad   = 0;

   logic [15:0] shl_exp;
   logic [15:0] shr_exp;

   alu16_exec dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .ALUOp     (ALUOp),
      .Funct     (Funct),
      .Opcode    (Opcode),
      .OperandA  (OperandA),
      .OperandB  (OperandB),
      .StoreData (StoreData),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .ALUCtrl   (ALUCtrl),
      .ALUOut    (ALUOut),
      .Zero      (Zero),
      .Overflow  (Overflow),
      .CarryOut  (CarryOut),
      .MemData   (MemData)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic op(input logic [1:0] a_op, input logic [3:0] opc,
                     input logic [1:0] fn, input logic [15:0] a,
                     input logic [15:0] b);
      ALUOp    = a_op;
      Opcode   = opc;
      Funct    = fn;
      OperandA = a;
      OperandB = b;
      #1;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   initial begin
`ifdef ALU16_EXEC_SHIFT_EN
      shl_exp = 16'h0030;
      shr_exp = 16'h0800;
`else
      shl_exp = 16'h0000;
      shr_exp = 16'h0000;
`endif
      Reset = 1'b1;
      MemWrite = 1'b0;
      MemRead = 1'b1;
      StoreData = 16'h0000;
      op(2'b00, 4'h0, 2'b00, 16'h0020, 16'h0000);
      tick();
      Reset = 1'b0;
      #1;
      chk("reset_mem", MemData, 16'h0000);

      op(2'b00, 4'h0, 2'b00, 16'h0010, 16'h0004);
      chk("add_ctrl", {12'd0, ALUCtrl}, 16'h0002);
      chk("add_out", ALUOut, 16'h0014);
      chk("add_zero", {15'd0, Zero}, 16'h0000);
      chk("add_carry", {15'd0, CarryOut}, 16'h0000);

      op(2'b01, 4'h0, 2'b00, 16'h1234, 16'h1234);
      chk("beq_ctrl", {12'd0, ALUCtrl}, 16'h000A);
      chk("beq_out", ALUOut, 16'h0000);
      chk("beq_zero", {15'd0, Zero}, 16'h0001);
      chk("beq_carry", {15'd0, CarryOut}, 16'h0001);

      op(2'b01, 4'h0, 2'b00, 16'h7FFF, 16'hFFFF);
      chk("sub_ovf_out", ALUOut, 16'h8000);
      chk("sub_ovf", {15'd0, Overflow}, 16'h0001);

      op(2'b00, 4'h0, 2'b00, 16'hFFFF, 16'h0001);
      chk("add_wrap_out", ALUOut, 16'h0000);
      chk("add_wrap_carry", {15'd0, CarryOut}, 16'h0001);
      chk("add_wrap_ovf", {15'd0, Overflow}, 16'h0000);

      op(2'b10, 4'h0, 2'b10, 16'hFFFF, 16'h0001);
      chk("slt_ctrl", {12'd0, ALUCtrl}, 16'h000B);
      chk("slt_out", ALUOut, 16'h0001);
      chk("slt_carry", {15'd0, CarryOut}, 16'h0000);

      op(2'b10, 4'h1, 2'b10, 16'h0003, 16'h0004);
      chk("sll_ctrl", {12'd0, ALUCtrl}, 16'h0006);
      chk("sll_out", ALUOut, shl_exp);

      op(2'b10, 4'h1, 2'b11, 16'h8000, 16'h0004);
      chk("srl_out", ALUOut, shr_exp);

      op(2'b10, 4'h0, 2'b11, 16'hF0F0, 16'h0FF0);
      chk("and_out", ALUOut, 16'h00F0);

      op(2'b11, 4'h6, 2'b00, 16'hF000, 16'h000F);
      chk("ori_out", ALUOut, 16'hF00F);

      op(2'b11, 4'h7, 2'b00, 16'hFFFF, 16'h00FF);
      chk("xori_ctrl", {12'd0, ALUCtrl}, 16'h0004);
      chk("xori_out", ALUOut, 16'hFF00);

      op(2'b11, 4'h4, 2'b00, 16'h0005, 16'h0003);
      chk("slti_out", ALUOut, 16'h0000);
      chk("slti_zero", {15'd0, Zero}, 16'h0001);

      op(2'b11, 4'hF, 2'b00, 16'h0001, 16'h0002);
      chk("undef_i_ctrl", {12'd0, ALUCtrl}, 16'h0002);
      chk("undef_i_out", ALUOut, 16'h0003);

      op(2'b10, 4'h2, 2'b01, 16'h0001, 16'h0002);
      chk("undef_r_ctrl", {12'd0, ALUCtrl}, 16'h0002);

      // store with concurrent read: pre-write contents visible
      op(2'b00, 4'h0, 2'b00, 16'h0020, 16'h0000);
      StoreData = 16'hBEEF;
      MemWrite = 1'b1;
      MemRead = 1'b1;
      #1;
      chk("rw_old", MemData, 16'h0000);
      tick();
      MemWrite = 1'b0;
      #1;
      chk("ld_20", MemData, 16'hBEEF);
      op(2'b00, 4'h0, 2'b00, 16'h0021, 16'h0000);
      chk("ld_21", MemData, 16'hBEEF);
      MemRead = 1'b0;
      #1;
      chk("ld_off", MemData, 16'h0000);

      op(2'b00, 4'h0, 2'b00, 16'h0020, 16'h0000);
      StoreData = 16'h1111;
      MemWrite = 1'b1;
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      MemWrite = 1'b0;
      MemRead = 1'b1;
      #1;
      chk("reset_prio", MemData, 16'h0000);

      op(2'b00, 4'h0, 2'b00, 16'h0102, 16'h0000);
      StoreData = 16'h1357;
      MemWrite = 1'b1;
      tick();
      MemWrite = 1'b0;
      op(2'b00, 4'h0, 2'b00, 16'h0002, 16'h0000);
      chk("wrap_ld", MemData, 16'h1357);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
